// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle sequencer and the shared datapath.
// The master side is the sequencer; the slave side is the datapath/memory.
interface multicycle_control_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_le;
    logic        mem_req;
    logic        mem_write;
    logic        mem_is_data;
    logic        ir_write;
    logic        mdr_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_b;
    logic [4:0]  alu_op;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        link;
    logic        retire;
    logic        illegal;
    logic        bus_error;
    logic [2:0]  state;

    modport master (
        input  instr, mem_ready, alu_le,
        output mem_req, mem_write, mem_is_data, ir_write, mdr_write,
        output pc_write, pc_src, alu_src_b, alu_op, reg_write, reg_dst,
        output mem_to_reg, link, retire, illegal, bus_error, state
    );

    modport slave (
        output instr, mem_ready, alu_le,
        input  mem_req, mem_write, mem_is_data, ir_write, mdr_write,
        input  pc_write, pc_src, alu_src_b, alu_op, reg_write, reg_dst,
        input  mem_to_reg, link, retire, illegal, bus_error, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 32-bit datapath.
// Drives datapath enables, memory handshake, timeout and illegal-op flags.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_wait;

    logic [5:0] w_op;
    logic       w_rtype;
    logic       w_nori;
    logic       w_lw;
    logic       w_sw;
    logic       w_jr;
    logic       w_jal;
    logic       w_bleu;
    logic       w_ill;
    logic       w_in_mem;
    logic       w_ack;
    logic       w_tmo;

    assign w_op    = bus.instr[31:26];
    assign w_rtype = (w_op == 6'b100000) || (w_op == 6'b100110) ||
                     (w_op == 6'b000100) || (w_op == 6'b000000) ||
                     (w_op == 6'b000010);
    assign w_nori  = (w_op == 6'b001110);
    assign w_lw    = (w_op == 6'b100011);
    assign w_sw    = (w_op == 6'b101011);
    assign w_jr    = (w_op == 6'b001000);
    assign w_jal   = (w_op == 6'b000011);
    assign w_bleu  = (w_op == 6'b010000);
    assign w_ill   = !(w_rtype || w_nori || w_lw || w_sw ||
                       w_jr || w_jal || w_bleu);

    // An ack in the timeout cycle wins, so timeout requires !mem_ready.
    assign w_in_mem = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_ack    = w_in_mem && bus.mem_ready;
    assign w_tmo    = w_in_mem && !bus.mem_ready &&
                      (r_wait == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (w_ack)
                        r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_jal || w_jr || w_ill)
                        r_state <= S_FETCH;
                    else
                        r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_bleu)
                        r_state <= S_FETCH;
                    else if (w_lw || w_sw)
                        r_state <= S_MEM;
                    else
                        r_state <= S_WB;
                end
                S_MEM: begin
                    if (w_ack)
                        r_state <= w_lw ? S_WB : S_FETCH;
                    else if (w_tmo)
                        r_state <= S_FETCH;
                end
                S_WB:    r_state <= S_FETCH;
                default: r_state <= S_FETCH;
            endcase

            // Zero outside FETCH/MEM, so any entry into them starts at 0.
            if (w_ack || w_tmo || !w_in_mem)
                r_wait <= '0;
            else
                r_wait <= r_wait + 1'b1;
        end
    end

    assign bus.state = r_state;

    always_comb begin
        bus.mem_req     = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_is_data = 1'b0;
        bus.ir_write    = 1'b0;
        bus.mdr_write   = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = 2'd0;
        bus.alu_src_b   = 1'b0;
        bus.alu_op      = 5'd0;
        bus.reg_write   = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.link        = 1'b0;
        bus.retire      = 1'b0;
        bus.illegal     = 1'b0;
        bus.bus_error   = 1'b0;
        if (rst_n) begin
            bus.alu_op = bus.instr[31:27];
            unique case (r_state)
                S_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.ir_write  = w_ack;
                    bus.pc_write  = w_ack;
                    bus.bus_error = w_tmo;
                end
                S_DECODE: begin
                    bus.pc_write  = w_jal || w_jr;
                    bus.pc_src    = w_jr ? 2'd3 : (w_jal ? 2'd2 : 2'd0);
                    bus.reg_write = w_jal;
                    bus.link      = w_jal;
                    bus.retire    = w_jal || w_jr;
                    bus.illegal   = w_ill;
                end
                S_EXEC: begin
                    bus.alu_src_b = w_nori || w_lw || w_sw;
                    bus.pc_write  = w_bleu && bus.alu_le;
                    bus.pc_src    = w_bleu ? 2'd1 : 2'd0;
                    bus.retire    = w_bleu;
                end
                S_MEM: begin
                    bus.mem_req     = 1'b1;
                    bus.mem_is_data = 1'b1;
                    bus.mem_write   = w_sw;
                    bus.mdr_write   = w_ack && w_lw;
                    bus.retire      = w_ack && w_sw;
                    bus.bus_error   = w_tmo;
                end
                S_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = w_rtype;
                    bus.mem_to_reg = w_lw;
                    bus.retire     = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed plan steps then random program,
// each cycle compared against a phase-level model of the instruction flow.
module tb_multicycle_control;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control #(
        .MEM_TIMEOUT(TO),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_write;
        logic       mem_is_data;
        logic       ir_write;
        logic       mdr_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_b;
        logic [4:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       link;
        logic       retire;
        logic       illegal;
        logic       bus_error;
    } out_t;

    typedef enum {C_R, C_NORI, C_LW, C_SW, C_JR, C_JAL, C_BLEU, C_ILL} cls_t;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;

    function automatic cls_t classify(input logic [5:0] op);
        case (op)
            6'b100000, 6'b100110, 6'b000100,
            6'b000000, 6'b000010: return C_R;
            6'b001110: return C_NORI;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b001000: return C_JR;
            6'b000011: return C_JAL;
            6'b010000: return C_BLEU;
            default:   return C_ILL;
        endcase
    endfunction

    // Zero-wait latency table plus the memory wait cycles spent.
    function automatic int lat(input cls_t c, input int fw, input int mw);
        case (c)
            C_JAL, C_JR, C_ILL: return 2 + fw;
            C_BLEU:             return 3 + fw;
            C_LW:               return 5 + fw + mw;
            C_SW:               return 4 + fw + mw;
            default:            return 4 + fw;
        endcase
    endfunction

    function automatic out_t base(input logic [2:0] st, input logic [31:0] ins);
        out_t e;
        e = '0;
        e.state = st;
        e.alu_op = ins[31:27];
        return e;
    endfunction

    function automatic out_t observe();
        out_t o;
        o.state       = bus.state;
        o.mem_req     = bus.mem_req;
        o.mem_write   = bus.mem_write;
        o.mem_is_data = bus.mem_is_data;
        o.ir_write    = bus.ir_write;
        o.mdr_write   = bus.mdr_write;
        o.pc_write    = bus.pc_write;
        o.pc_src      = bus.pc_src;
        o.alu_src_b   = bus.alu_src_b;
        o.alu_op      = bus.alu_op;
        o.reg_write   = bus.reg_write;
        o.reg_dst     = bus.reg_dst;
        o.mem_to_reg  = bus.mem_to_reg;
        o.link        = bus.link;
        o.retire      = bus.retire;
        o.illegal     = bus.illegal;
        o.bus_error   = bus.bus_error;
        return o;
    endfunction

    // Called at posedge+1: drive, sample mid-cycle, advance one clock.
    task automatic step(input out_t e, input logic rdy, input string tag);
        out_t o;
        bus.mem_ready = rdy;
        #2;
        o = observe();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, o, e);
        end
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input int fw, output bit ok);
        out_t e;
        ok = 1'b0;
        for (int k = 0; k <= TO; k++) begin
            e = base(3'd0, ins);
            e.mem_req = 1'b1;
            if (k == fw) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
                step(e, 1'b1, "fetch_ack");
                ok = 1'b1;
                return;
            end
            if (k == TO) e.bus_error = 1'b1;
            step(e, 1'b0, (k == TO) ? "fetch_tmo" : "fetch_wait");
        end
    endtask

    task automatic run(input logic [31:0] ins, input int fw, input int mw,
                       input logic le, input string tag);
        cls_t c;
        out_t e;
        bit   ok;
        bit   acked;
        int   start;
        c = classify(ins[31:26]);
        bus.instr = ins;
        bus.alu_le = le;
        start = ncyc;
        fetch(ins, fw, ok);
        if (!ok) return;

        e = base(3'd1, ins);
        case (c)
            C_JAL: begin
                e.pc_write = 1'b1; e.pc_src = 2'd2;
                e.reg_write = 1'b1; e.link = 1'b1; e.retire = 1'b1;
            end
            C_JR: begin
                e.pc_write = 1'b1; e.pc_src = 2'd3; e.retire = 1'b1;
            end
            C_ILL: e.illegal = 1'b1;
            default: ;
        endcase
        step(e, 1'($urandom_range(0, 1)), "decode");

        if (!(c inside {C_JAL, C_JR, C_ILL})) begin
            e = base(3'd2, ins);
            e.alu_src_b = (c inside {C_NORI, C_LW, C_SW});
            if (c == C_BLEU) begin
                e.pc_write = le; e.pc_src = 2'd1; e.retire = 1'b1;
            end
            step(e, 1'($urandom_range(0, 1)), "exec");

            if (c inside {C_LW, C_SW}) begin
                acked = 1'b0;
                for (int k = 0; k <= TO && !acked; k++) begin
                    e = base(3'd3, ins);
                    e.mem_req = 1'b1;
                    e.mem_is_data = 1'b1;
                    e.mem_write = (c == C_SW);
                    if (k == mw) begin
                        if (c == C_LW) e.mdr_write = 1'b1;
                        else e.retire = 1'b1;
                        step(e, 1'b1, "mem_ack");
                        acked = 1'b1;
                    end else begin
                        if (k == TO) e.bus_error = 1'b1;
                        step(e, 1'b0, (k == TO) ? "mem_tmo" : "mem_wait");
                    end
                end
                if (!acked) return;
            end

            if (c inside {C_R, C_NORI, C_LW}) begin
                e = base(3'd4, ins);
                e.reg_write = 1'b1;
                e.reg_dst = (c == C_R);
                e.mem_to_reg = (c == C_LW);
                e.retire = 1'b1;
                step(e, 1'($urandom_range(0, 1)), "wb");
            end
        end

        checks++;
        assert (ncyc - start == lat(c, fw, mw)) else begin
            errors++;
            $error("FAIL latency_%s: got %0d want %0d",
                   tag, ncyc - start, lat(c, fw, mw));
        end
    endtask

    logic [5:0] ops [11];
    logic [5:0] op;
    bit         ok;
    out_t       e;

    initial begin
        ops = '{6'b100000, 6'b100110, 6'b000100, 6'b000000, 6'b000010,
                6'b001110, 6'b100011, 6'b101011, 6'b001000, 6'b000011,
                6'b010000};
        bus.instr = 32'h8000_0000;
        bus.mem_ready = 1'b1;
        bus.alu_le = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        e = '0;
        step(e, 1'b1, "reset_outputs");
        rst_n = 1'b1;

        run(32'h8000_0000, 0, 0, 1'b0, "and");
        run(32'h8C00_0000, 3, 3, 1'b0, "lw_wait");
        run(32'h4000_0000, 0, 0, 1'b1, "bleu_taken");
        run(32'h4000_0000, 0, 0, 1'b0, "bleu_not");
        run(32'h0C00_0000, 0, 0, 1'b0, "jal");
        run(32'h2000_0000, 0, 0, 1'b0, "jr");

        bus.instr = 32'h8000_0000;
        fetch(32'h8000_0000, TO + 1, ok);
        run(32'h8000_0000, TO, 0, 1'b0, "ack_at_timeout");
        run(32'hAC00_0000, 0, TO + 1, 1'b0, "sw_mem_tmo");
        run(32'h8C00_0000, 1, TO, 1'b0, "lw_ack_at_timeout");
        run(32'hFC00_0000, 0, 0, 1'b0, "illegal");

        // Reset lands while the store is in MEM.
        bus.instr = 32'hAC00_0000;
        fetch(32'hAC00_0000, 0, ok);
        e = base(3'd1, 32'hAC00_0000);
        step(e, 1'b0, "sw_decode");
        e = base(3'd2, 32'hAC00_0000);
        e.alu_src_b = 1'b1;
        step(e, 1'b0, "sw_exec");
        rst_n = 1'b0;
        e = '0;
        e.state = 3'd3;
        step(e, 1'b1, "reset_in_mem");
        rst_n = 1'b1;
        run(32'hAC00_0000, 0, 0, 1'b0, "sw_after_reset");

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0)
                op = 6'($urandom);
            else
                op = ops[$urandom_range(0, 10)];
            run({op, 26'($urandom)}, $urandom_range(0, TO + 2),
                $urandom_range(0, TO + 2), 1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the custom 32-bit ISA datapath (shared PC/IR/ALU/memory port). It replaces single-cycle decode.
- It walks each instruction through FETCH, DECODE, EXEC, MEM and WB, and handshakes with a shared instruction/data memory port.
- It generates all datapath enables and flags memory timeouts and illegal opcodes.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles a memory request may stay un-acked before abort. Legal range 1..255.
- CNT_W, 8: width of the wait counter. Must satisfy MEM_TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- instr  in  32  IR contents; opcode = instr[31:26]
- mem_ready  in  1  memory ack; request completes in any cycle mem_req&mem_ready
- alu_le  in  1  ALU result rs <= rt (unsigned), valid in EXEC
- mem_req  out  1  memory request
- mem_write  out  1  store strobe, qualified by mem_req
- mem_is_data  out  1  0 = address from PC, 1 = address from ALU result
- ir_write  out  1  load IR from memory read data
- mdr_write  out  1  load MDR from memory read data
- pc_write  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = register rs
- alu_src_b  out  1  1 = immediate operand
- alu_op  out  5  ALU function
- reg_write  out  1  register file write enable
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  write-back data from MDR
- link  out  1  write PC+4 to $31
- retire  out  1  one-cycle pulse per completed instruction
- illegal  out  1  one-cycle pulse on an undefined opcode
- bus_error  out  1  one-cycle pulse on memory timeout
- state  out  3  FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4

Behaviour:
- Opcodes: and 100000, nor 100110, not 000100, rolv 000000, rorv 000010 (R-type); nori 001110; lw 100011; sw 101011; jr 001000; jal 000011; bleu 010000. All others are illegal.
- Reset: on a clk edge with rst_n = 0, state <= FETCH and the wait counter <= 0. While rst_n = 0, every output except state is forced to 0.
- Outputs are combinational from state, instr and mem_ready. Default value is 0; alu_op defaults to instr[31:27] in every state.
- FETCH:
  - mem_req = 1, mem_is_data = 0.
  - On mem_ready: ir_write = 1, pc_write = 1, pc_src = 0, go to DECODE.
- DECODE (1 cycle):
  - jal: pc_write, pc_src = 2, reg_write, link, retire; go to FETCH.
  - jr: pc_write, pc_src = 3, retire; go to FETCH.
  - illegal: illegal = 1; go to FETCH. PC is already advanced; no retire.
  - Otherwise: go to EXEC.
- EXEC (1 cycle):
  - alu_src_b = 1 for nori, lw and sw.
  - bleu: pc_write = alu_le, pc_src = 1, retire; go to FETCH.
  - lw/sw: go to MEM.
  - R-type/nori: go to WB.
- MEM:
  - mem_req = 1, mem_is_data = 1, mem_write = 1 for sw.
  - On mem_ready, lw: mdr_write, go to WB.
  - On mem_ready, sw: retire, go to FETCH.
- WB (1 cycle):
  - reg_write = 1.
  - reg_dst = 1 for R-type, 0 for nori/lw.
  - mem_to_reg = 1 for lw.
  - retire; go to FETCH.
- Wait counter:
  - Cleared on entry to FETCH or MEM and on any ack.
  - Increments each cycle mem_req = 1 and mem_ready = 0.
  - When it equals MEM_TIMEOUT with no ack, in the same cycle: bus_error = 1, mem_req still 1, no ir/mdr/pc write.
  - Next state is FETCH (re-fetches the same PC), with no retire.
  - An ack in the timeout cycle wins and completes normally, with no bus_error.
- mem_ready is ignored outside FETCH and MEM.
- Reset asserted mid-instruction abandons it. No write enable fires in a cycle where rst_n = 0.
- Latencies in cycles with zero-wait memory: jal/jr 2; bleu 3; R-type/nori/sw 4; lw 5.

Test Plan:
- Reset, then zero-wait memory, instr = and (0x80000000): states 0,1,2,4,0. ir_write and pc_write in cycle 1. reg_write = 1 and reg_dst = 1 in cycle 4. retire in cycle 4 only.
- lw (0x8C000000) with mem_ready delayed 3 cycles in both FETCH and MEM: mem_req held for 4 cycles each, mem_is_data 0 then 1. mdr_write on the MEM ack. WB shows mem_to_reg = 1, reg_dst = 0. Total 11 cycles.
- bleu (0x40000000) with alu_le = 1, then again with alu_le = 0: EXEC shows pc_write = 1 with pc_src = 1, then pc_write = 0. Both runs pulse retire and return to FETCH.
- jal (0x0C000000) then jr (0x20000000): in DECODE, jal shows pc_src = 2 with reg_write = 1 and link = 1; jr shows pc_src = 3 with reg_write = 0. Each takes 2 cycles.
- MEM_TIMEOUT = 4, mem_ready held 0 in FETCH: bus_error pulses on the 5th request cycle, state goes to FETCH, no ir_write. Repeat with ack in the 5th cycle: normal completion, no bus_error.
- Opcode 111111 gives illegal = 1 in DECODE with no retire, then FETCH. rst_n = 0 during MEM of sw gives mem_write = 0 that cycle and state = 0 next cycle.
